// File: rtl/mem_access_unit_if.sv
// Bundles the request/response handshake and data-memory port of mem_access_unit.
// master = execute stage plus data memory; slave = the access unit.
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_r_addr;
    logic [31:0] mem_w_addr;
    logic [31:0] mem_w_data;
    logic [3:0]  mem_we;
    logic [31:0] mem_r_data;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
               rsp_ready, mem_r_data,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_r_addr, mem_w_addr, mem_w_data, mem_we
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
               rsp_ready, mem_r_data,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_r_addr, mem_w_addr, mem_w_data, mem_we
    );
endinterface

// File: rtl/mem_access_unit.sv
// Byte-addressed load/store front end for a word-wide data memory: lane-shifts stores,
// extracts and extends loads, and splits misaligned accesses into two word accesses.
module mem_access_unit #(
    parameter int unsigned MEM_WORDS = 24576,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input logic              clk,
    input logic              rst_n,
    mem_access_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_e;

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] widx_q, widx_d;
    logic [31:0] wdata_q, wdata_d;
    logic        split_q, split_d;
    logic        err_q, err_d;
    logic [31:0] rbuf_q, rbuf_d;

    logic [31:0] rel_addr;
    logic [31:0] req_widx;
    logic [2:0]  req_nbytes;
    logic        req_split;
    logic        req_err;
    logic [3:0]  byte_mask;
    logic [7:0]  lanes;
    logic [63:0] st_shift;
    logic [31:0] load_result;

    // Request decode, evaluated while IDLE so it can be latched at the accept edge.
    always_comb begin
        rel_addr = bus.req_addr - BASE_ADDR;
        req_widx = {2'b00, rel_addr[31:2]};
        unique case (bus.req_size)
            2'd0:    req_nbytes = 3'd1;
            2'd1:    req_nbytes = 3'd2;
            default: req_nbytes = 3'd4;
        endcase
        req_split = ({1'b0, rel_addr[1:0]} + req_nbytes) > 3'd4;
        req_err   = (bus.req_size == 2'd3) || (bus.req_addr < BASE_ADDR) ||
                    (req_widx >= MEM_WORDS) ||
                    (req_split && (req_widx + 32'd1 >= MEM_WORDS));
    end

    // Lanes and data span two words: low half goes to widx, high half to widx+1.
    always_comb begin
        unique case (size_q)
            2'd0:    byte_mask = 4'b0001;
            2'd1:    byte_mask = 4'b0011;
            default: byte_mask = 4'b1111;
        endcase
        lanes    = {4'b0000, byte_mask} << off_q;
        st_shift = {32'b0, wdata_q} << {off_q, 3'b000};
        unique case (size_q)
            2'd0:    load_result = {{24{~uns_q & rbuf_q[7]}}, rbuf_q[7:0]};
            2'd1:    load_result = {{16{~uns_q & rbuf_q[15]}}, rbuf_q[15:0]};
            default: load_result = rbuf_q;
        endcase
    end

    always_comb begin
        // NOTE: every output and next-state value gets a default first, so no path
        // through the case statement can infer a latch.
        state_d        = state_q;
        we_d           = we_q;
        size_d         = size_q;
        uns_d          = uns_q;
        off_d          = off_q;
        widx_d         = widx_q;
        wdata_d        = wdata_q;
        split_d        = split_q;
        err_d          = err_q;
        rbuf_d         = rbuf_q;
        bus.req_ready  = 1'b0;
        bus.rsp_valid  = 1'b0;
        bus.rsp_rdata  = 32'h0;
        bus.rsp_err    = 1'b0;
        bus.mem_r_addr = 32'h0;
        bus.mem_w_data = 32'h0;
        bus.mem_we     = 4'b0000;

        unique case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    size_d  = bus.req_size;
                    uns_d   = bus.req_unsigned;
                    off_d   = rel_addr[1:0];
                    widx_d  = req_widx;
                    wdata_d = bus.req_wdata;
                    split_d = req_split;
                    err_d   = req_err;
                    rbuf_d  = 32'h0;
                    state_d = req_err ? RESP : ACC0;
                end
            end
            ACC0: begin
                bus.mem_r_addr = widx_q;
                if (we_q) begin
                    bus.mem_we     = lanes[3:0];
                    bus.mem_w_data = st_shift[31:0];
                end else begin
                    rbuf_d = bus.mem_r_data >> {off_q, 3'b000};
                end
                state_d = split_q ? ACC1 : RESP;
            end
            ACC1: begin
                bus.mem_r_addr = widx_q + 32'd1;
                if (we_q) begin
                    bus.mem_we     = lanes[7:4];
                    bus.mem_w_data = st_shift[63:32];
                end else begin
                    // Only reached when off_q is non-zero, so the shift stays below 32.
                    rbuf_d = rbuf_q | (bus.mem_r_data << (6'd32 - {1'b0, off_q, 3'b000}));
                end
                state_d = RESP;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_err   = err_q;
                bus.rsp_rdata = (err_q || we_q) ? 32'h0 : load_result;
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.mem_w_addr = bus.mem_r_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            off_q   <= 2'd0;
            widx_q  <= 32'h0;
            wdata_q <= 32'h0;
            split_q <= 1'b0;
            err_q   <= 1'b0;
            rbuf_q  <= 32'h0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            off_q   <= off_d;
            widx_q  <= widx_d;
            wdata_q <= wdata_d;
            split_q <= split_d;
            err_q   <= err_d;
            rbuf_q  <= rbuf_d;
        end
    end
endmodule
